// File: rtl/erx_pkg.sv
// Shared types and constants for the ether_rx host-side sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package erx_pkg;

  localparam logic [3:0] CMD_GETSIZE = 4'd1;
  localparam logic [3:0] CMD_GETDATA = 4'd2;

  localparam int CNT_W  = 16;
  localparam int IDX_W  = 9;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GETSIZE,
    S_GETDATA,
    S_PUSH,
    S_ABORT
  } state_t;

  // Saturating increment for the error counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/erx_ctrl_if.sv
// ether_rx command/response toggle handshake plus the outgoing word stream.
// Latency: n/a (wiring only).
// Backpressure: out_ready stalls the stream; the erx side is toggle-paced.
interface erx_ctrl_if;
  import erx_pkg::*;

  logic              erx_ready;
  logic [DATA_W-1:0] erx_data;
  logic              erx_dv;
  logic              erx_cs;
  logic [3:0]        erx_cmd;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_first;
  logic              out_last;
  logic              out_err;

  modport master (
    input  erx_ready, erx_data, erx_dv, out_ready,
    output erx_cs, erx_cmd, out_valid, out_data, out_first, out_last, out_err
  );

  modport slave (
    output erx_ready, erx_data, erx_dv, out_ready,
    input  erx_cs, erx_cmd, out_valid, out_data, out_first, out_last, out_err
  );

endinterface

// File: rtl/erx_toggle_det.sv
// Detects a level change on a toggle-handshake line (shared with the tx controller).
// Latency: combinational tog against a one-cycle registered copy of the line.
// Backpressure: none; tog is a single-cycle event and is masked during reset.
module erx_toggle_det (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic tog
);

  logic lvl_q;

  // Track the line every cycle, including reset, so no stale toggle appears after reset.
  always_ff @(posedge clk) begin
    lvl_q <= lvl;
  end

  assign tog = (lvl ^ lvl_q) & ~rst;

endmodule

// File: rtl/erx_ctrl.sv
// Reads frames out of ether_rx (GETSIZE, then GETDATA per word) onto a word stream.
// Latency: one cycle from response toggle to out_valid; commands issue one cycle after entry.
// Backpressure: out_ready holds the pending word; no new command is issued while stalled.
module erx_ctrl
  import erx_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic             erxc_clk,
  input  logic             erxc_rst,
  input  logic             enable,
  erx_ctrl_if.master       bus,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t           state;
  logic             tog;
  logic             issued;
  logic             dv_seen;
  logic             abort_pend;
  logic             abort_to_idle;
  logic             started;
  logic [IDX_W-1:0] size;
  logic [IDX_W-1:0] idx;
  logic [TMO_W-1:0] tmo;

  erx_toggle_det u_tog (
    .clk (erxc_clk),
    .rst (erxc_rst),
    .lvl (bus.erx_ready),
    .tog (tog)
  );

  // A frame counts as started once any of its words has been accepted.
  assign started = (state == S_GETDATA) && (idx != '0);
  assign busy    = (state != S_IDLE);

  // Frame sequencer: command issue, response capture, stream push, abort and timeout.
  always_ff @(posedge erxc_clk) begin
    if (erxc_rst) begin
      state         <= S_IDLE;
      issued        <= 1'b0;
      dv_seen       <= 1'b0;
      abort_pend    <= 1'b0;
      abort_to_idle <= 1'b0;
      size          <= '0;
      idx           <= '0;
      tmo           <= '0;
      frame_cnt     <= '0;
      err_cnt       <= '0;
      bus.erx_cs    <= 1'b0;
      bus.erx_cmd   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_err   <= 1'b0;
    end else begin
      // A PHY data-valid while busy means a new frame is overwriting the buffer.
      if (bus.erx_dv && state != S_IDLE) dv_seen <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (tog) begin
            if (enable) begin
              state   <= S_GETSIZE;
              dv_seen <= 1'b0;
            end else begin
              err_cnt <= sat_inc(err_cnt);
            end
          end
        end

        S_GETSIZE, S_GETDATA: begin
          if (tog) begin
            bus.erx_cs <= 1'b0;
            issued     <= 1'b0;
            if (dv_seen) begin
              if (started) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= '0;
                bus.out_first <= 1'b0;
                bus.out_last  <= 1'b1;
                bus.out_err   <= 1'b1;
                abort_to_idle <= 1'b0;
                err_cnt       <= sat_inc(err_cnt);
                state         <= S_ABORT;
              end else begin
                // Nothing delivered yet: just start over on the newer frame.
                dv_seen <= 1'b0;
                state   <= S_GETSIZE;
              end
            end else if (state == S_GETSIZE) begin
              size <= bus.erx_data[IDX_W-1:0];
              idx  <= '0;
              if (bus.erx_data[IDX_W-1:0] == '0) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
                state     <= S_IDLE;
              end else begin
                state <= S_GETDATA;
              end
            end else begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= bus.erx_data;
              bus.out_first <= (idx == '0);
              bus.out_last  <= (idx == size - IDX_W'(1));
              bus.out_err   <= 1'b0;
              state         <= S_PUSH;
            end
          end else if (!issued) begin
            bus.erx_cs  <= 1'b1;
            bus.erx_cmd <= (state == S_GETSIZE) ? CMD_GETSIZE : CMD_GETDATA;
            issued      <= 1'b1;
            tmo         <= '0;
          end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
            bus.erx_cs <= 1'b0;
            issued     <= 1'b0;
            err_cnt    <= sat_inc(err_cnt);
            if (started) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= '0;
              bus.out_first <= 1'b0;
              bus.out_last  <= 1'b1;
              bus.out_err   <= 1'b1;
              abort_to_idle <= 1'b1;
              state         <= S_ABORT;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end

        S_PUSH: begin
          if (tog) abort_pend <= 1'b1;
          if (bus.out_ready) begin
            idx        <= idx + IDX_W'(1);
            abort_pend <= 1'b0;
            if (bus.out_last) begin
              // The frame was fully read before the overwrite; finish it, then chase the new one.
              bus.out_valid <= 1'b0;
              frame_cnt     <= frame_cnt + CNT_W'(1);
              if (tog || abort_pend) begin
                dv_seen <= 1'b0;
                state   <= S_GETSIZE;
              end else begin
                state <= S_IDLE;
              end
            end else if (tog || abort_pend) begin
              bus.out_data  <= '0;
              bus.out_first <= 1'b0;
              bus.out_last  <= 1'b1;
              bus.out_err   <= 1'b1;
              abort_to_idle <= 1'b0;
              err_cnt       <= sat_inc(err_cnt);
              state         <= S_ABORT;
            end else begin
              bus.out_valid <= 1'b0;
              state         <= S_GETDATA;
            end
          end
        end

        S_ABORT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_err   <= 1'b0;
            if (abort_to_idle) begin
              state <= S_IDLE;
            end else begin
              dv_seen <= 1'b0;
              state   <= S_GETSIZE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_erx_ctrl.sv
// Directed bench for erx_ctrl with a behavioural ether_rx responder.
// Latency: n/a.
// Backpressure: out_ready is driven by the scenarios.
module tb_erx_ctrl;
  import erx_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic        f;
    logic        l;
    logic        e;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  erx_ctrl_if bus();

  erx_ctrl #(.TIMEOUT(1024)) dut (
    .erxc_clk  (clk),
    .erxc_rst  (rst),
    .enable    (enable),
    .bus       (bus),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Scenario-owned model controls.
  int          m_size     = 0;
  logic [31:0] m_words [16];
  int          resp_limit = -1;
  int          kick_req   = 0;

  // Model-owned state.
  int   kick_done  = 0;
  int   resp_count = 0;
  int   m_hold     = 0;
  int   m_rd       = 0;
  int   cs_rises   = 0;
  logic cs_prev    = 1'b0;

  beat_t beats[$];

  // ether_rx stand-in: works on negedge, 17-cycle hold-off after each toggle.
  initial begin
    bus.erx_ready = 1'b0;
    bus.erx_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.erx_cs && !cs_prev) cs_rises++;
      cs_prev = bus.erx_cs;
      if (kick_req != kick_done) begin
        kick_done++;
        bus.erx_ready = ~bus.erx_ready;
        m_hold = 17;
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (bus.erx_cs && (resp_limit < 0 || resp_count < resp_limit)) begin
        if (bus.erx_cmd == CMD_GETSIZE) begin
          bus.erx_data = 32'(m_size);
          m_rd = 0;
        end else begin
          bus.erx_data = m_words[m_rd];
          m_rd++;
        end
        resp_count++;
        bus.erx_ready = ~bus.erx_ready;
        m_hold = 17;
      end
    end
  end

  // Stream monitor: the handshake values seen mid-cycle are those at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready)
        beats.push_back({bus.out_data, bus.out_first, bus.out_last, bus.out_err});
    end
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_beats(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (beats.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; bus.out_ready = 1'b1; bus.erx_dv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (bus.erx_cs !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b want 0", bus.erx_cs); end
    n_cmp++; if (bus.erx_cmd !== 4'd0) begin n_fail++; $display("FAIL reset_cmd: got %h want 0", bus.erx_cmd); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if ({bus.out_first, bus.out_last, bus.out_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.out_first, bus.out_last, bus.out_err}); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int base, cs0;
    bit ok;
    beat_t exp [3];
    base = beats.size(); cs0 = cs_rises;
    m_size = 3; m_words[0] = 32'h11111111; m_words[1] = 32'h22222222; m_words[2] = 32'h33333333;
    exp[0] = {32'h11111111, 1'b1, 1'b0, 1'b0};
    exp[1] = {32'h22222222, 1'b0, 1'b0, 1'b0};
    exp[2] = {32'h33333333, 1'b0, 1'b1, 1'b0};
    kick_req++;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_done: busy got %b want 0", busy); end
    n_cmp++; if (beats.size() - base !== 3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", beats.size() - base); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (beats[base + i] !== exp[i]) begin n_fail++; $display("FAIL basic_beat%0d: got %h want %h", i, beats[base + i], exp[i]); end
    end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
    n_cmp++; if (cs_rises - cs0 !== 4) begin n_fail++; $display("FAIL basic_cs_count: got %0d want 4", cs_rises - cs0); end
  endtask

  task automatic test_backpressure();
    int base;
    bit ok, stable, cs_low;
    beat_t held, cur, exp;
    base = beats.size();
    m_size = 4;
    for (int i = 0; i < 4; i++) m_words[i] = 32'hA0000001 + 32'(i);
    kick_req++;
    wait_beats(base + 1, ok);
    bus.out_ready = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_first_beat: got %0d beats want 1", beats.size() - base); end
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin ok = 1'b1; break; end
    end
    held = {bus.out_data, bus.out_first, bus.out_last, bus.out_err};
    exp  = {32'hA0000002, 1'b0, 1'b0, 1'b0};
    n_cmp++; if (held !== exp) begin n_fail++; $display("FAIL bp_held_word: got %h want %h", held, exp); end
    stable = 1'b1; cs_low = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      cur = {bus.out_data, bus.out_first, bus.out_last, bus.out_err};
      if (cur !== held || bus.out_valid !== 1'b1) stable = 1'b0;
      if (bus.erx_cs !== 1'b0) cs_low = 1'b0;
    end
    n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b want 1", stable); end
    n_cmp++; if (cs_low !== 1'b1) begin n_fail++; $display("FAIL bp_cs_low: got %b want 1", cs_low); end
    bus.out_ready = 1'b1;
    wait_idle(ok);
    n_cmp++; if (beats.size() - base !== 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", beats.size() - base); end
    for (int i = 0; i < 4; i++) begin
      exp = {32'hA0000001 + 32'(i), i == 0, i == 3, 1'b0};
      n_cmp++; if (beats[base + i] !== exp) begin n_fail++; $display("FAIL bp_beat%0d: got %h want %h", i, beats[base + i], exp); end
    end
    n_cmp++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_frame_cnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_size_zero();
    int base;
    bit ok;
    base = beats.size();
    m_size = 0;
    kick_req++;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL zero_done: busy got %b want 0", busy); end
    n_cmp++; if (beats.size() - base !== 0) begin n_fail++; $display("FAIL zero_count: got %0d want 0", beats.size() - base); end
    n_cmp++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL zero_frame_cnt: got %0d want 3", frame_cnt); end
  endtask

  task automatic test_dv_abort();
    int base;
    bit ok;
    beat_t exp [4];
    base = beats.size();
    m_size = 5;
    for (int i = 0; i < 5; i++) m_words[i] = 32'hD0000001 + 32'(i);
    exp[0] = {32'hD0000001, 1'b1, 1'b0, 1'b0};
    exp[1] = {32'h00000000, 1'b0, 1'b1, 1'b1};
    exp[2] = {32'hE0000001, 1'b1, 1'b0, 1'b0};
    exp[3] = {32'hE0000002, 1'b0, 1'b1, 1'b0};
    kick_req++;
    wait_beats(base + 1, ok);
    bus.erx_dv = 1'b1;
    @(posedge clk); #1;
    bus.erx_dv = 1'b0;
    m_size = 2; m_words[0] = 32'hE0000001; m_words[1] = 32'hE0000002;
    wait_idle(ok);
    n_cmp++; if (beats.size() - base !== 4) begin n_fail++; $display("FAIL dv_count: got %0d want 4", beats.size() - base); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (beats[base + i] !== exp[i]) begin n_fail++; $display("FAIL dv_beat%0d: got %h want %h", i, beats[base + i], exp[i]); end
    end
    n_cmp++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL dv_err_cnt: got %0d want 1", err_cnt); end
    n_cmp++; if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL dv_frame_cnt: got %0d want 4", frame_cnt); end
  endtask

  task automatic test_timeout();
    int base, hi;
    bit ok;
    beat_t exp [2];
    base = beats.size();
    m_size = 3;
    for (int i = 0; i < 3; i++) m_words[i] = 32'hF0000001 + 32'(i);
    exp[0] = {32'hF0000001, 1'b1, 1'b0, 1'b0};
    exp[1] = {32'h00000000, 1'b0, 1'b1, 1'b1};
    resp_limit = resp_count + 2;
    kick_req++;
    wait_beats(base + 1, ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.erx_cs) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tmo_cs_issue: cs got %b want 1", bus.erx_cs); end
    hi = 0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk); #1;
      hi++;
      if (!bus.erx_cs) break;
    end
    n_cmp++; if (hi !== 1024) begin n_fail++; $display("FAIL tmo_cs_width: got %0d cycles want 1024", hi); end
    wait_idle(ok);
    resp_limit = -1;
    n_cmp++; if (beats.size() - base !== 2) begin n_fail++; $display("FAIL tmo_count: got %0d want 2", beats.size() - base); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (beats[base + i] !== exp[i]) begin n_fail++; $display("FAIL tmo_beat%0d: got %h want %h", i, beats[base + i], exp[i]); end
    end
    n_cmp++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL tmo_err_cnt: got %0d want 2", err_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b want 0", busy); end
    n_cmp++; if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL tmo_frame_cnt: got %0d want 4", frame_cnt); end
  endtask

  task automatic test_disabled();
    int base;
    base = beats.size();
    enable = 1'b0;
    kick_req++;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dis_busy: got %b want 0", busy); end
    n_cmp++; if (err_cnt !== 16'd3) begin n_fail++; $display("FAIL dis_err_cnt: got %0d want 3", err_cnt); end
    n_cmp++; if (beats.size() - base !== 0) begin n_fail++; $display("FAIL dis_count: got %0d want 0", beats.size() - base); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    beat_t exp;
    base = beats.size();
    bus.out_ready = 1'b0;
    m_size = 3;
    for (int i = 0; i < 3; i++) m_words[i] = 32'h71000001 + 32'(i);
    kick_req++;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin ok = 1'b1; break; end
    end
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rm_valid_seen: got %b want 1", bus.out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_frame_cnt_clr: got %0d want 0", frame_cnt); end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_no_false_tog: busy got %b want 0", busy); end
    m_size = 1; m_words[0] = 32'h5A5A5A5A;
    exp = {32'h5A5A5A5A, 1'b1, 1'b1, 1'b0};
    kick_req++;
    wait_idle(ok);
    n_cmp++; if (beats.size() - base !== 1) begin n_fail++; $display("FAIL rm_count: got %0d want 1", beats.size() - base); end
    n_cmp++; if (beats[base] !== exp) begin n_fail++; $display("FAIL rm_beat: got %h want %h", beats[base], exp); end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL rm_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_size_zero();
    test_dv_abort();
    test_timeout();
    test_disabled();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/erx_ctrl.md
Name: erx_ctrl

Overview:
Host-side sequencer for the ether_rx receive buffer. It detects end-of-frame toggles on erx_ready and issues GETSIZE followed by one GETDATA per word over the erx_cs/erx_cmd toggle handshake. Frame words go out on a valid/ready stream with first/last/err markers. Frames corrupted by a new arrival or a stalled receiver are aborted cleanly and counted.

Parameters:
TIMEOUT, 1024, cycles to wait for an erx_ready toggle after a command before aborting
CMD_GETSIZE, 1, erx_cmd code for the size query
CMD_GETDATA, 2, erx_cmd code for the next-word read

Ports:
erxc_clk  in  1  single clock, same net as the ether_rx clock (ether_rx works on negedge, this block on posedge)
erxc_rst  in  1  synchronous, active-high reset
enable  in  1  0 = do not start new frames (a frame in progress completes)
erx_ready  in  1  toggle handshake from ether_rx
erx_data  in  32  response word from ether_rx
erx_dv  in  1  snoop of the PHY data-valid line
erx_cs  out  1  command strobe to ether_rx
erx_cmd  out  4  command code
out_valid  out  1  stream word valid
out_ready  in  1  stream backpressure
out_data  out  32  frame word
out_first  out  1  first word of frame
out_last  out  1  last word of frame
out_err  out  1  frame aborted; qualifies out_last word
busy  out  1  state != S_IDLE
frame_cnt  out  16  frames fully delivered (wraps)
err_cnt  out  16  aborts plus timeouts (saturates at 0xFFFF)

Behaviour:
- Reset (erxc_rst=1 at posedge):
  - State S_IDLE; all outputs 0; counters cleared.
  - ready_q <= erx_ready, so there is no false toggle after reset.
- Toggle detect: tog = erx_ready ^ ready_q; ready_q updates every cycle.
- dv_seen flag:
  - Set when erx_dv=1 in any state except S_IDLE.
  - Cleared on entry to S_GETSIZE.
- S_IDLE:
  - tog && enable -> S_GETSIZE.
  - tog && !enable -> frame dropped, err_cnt++.
- S_GETSIZE:
  - Drive erx_cs=1, erx_cmd=CMD_GETSIZE until tog.
  - On tog: drop erx_cs the next cycle; size <= erx_data[8:0]; idx <= 0.
  - size==0 -> frame_cnt++, S_IDLE.
  - Otherwise -> S_GETDATA.
- S_GETDATA:
  - Drive erx_cs=1, erx_cmd=CMD_GETDATA until tog.
  - On tog (dv_seen=0): latch erx_data into out_data; out_first=(idx==0); out_last=(idx==size-1) -> S_PUSH.
- S_PUSH:
  - out_valid=1; out_data and flags are held stable until out_ready.
  - Accept: idx++; last word -> frame_cnt++, S_IDLE; else -> S_GETDATA.
  - erx_cs=0 throughout S_PUSH.
- Command latency: erx_cs is deasserted one cycle after tog. ether_rx sits in READY/WAIT for 17 clocks after any toggle, so no duplicate command can be taken.
- Abort: a tog while dv_seen=1 (S_GETSIZE/S_GETDATA), or any tog in S_PUSH, marks a new frame that has overwritten the buffer.
  - If a word of the current frame is already delivered or pending: present (after any pending word is accepted) one word with data=0, out_last=1, out_err=1.
  - err_cnt++, then -> S_GETSIZE for the new frame.
  - If no word has been delivered yet: silently restart in S_GETSIZE.
- Timeout:
  - Counter runs in S_GETSIZE/S_GETDATA and resets on each command issue.
  - Reaching TIMEOUT-1 drops erx_cs, err_cnt++, and emits the err/last word if the frame is started; then -> S_IDLE.
- Reset mid-frame: immediate return to S_IDLE; out_valid drops in the same cycle; ether_rx is left untouched.
- Widths: idx and size are 9 bits; size values 1..511 are valid.

Decomposition:
- Package erx_pkg:
  - CMD_GETSIZE/CMD_GETDATA constants.
  - State enum (S_IDLE, S_GETSIZE, S_GETDATA, S_PUSH, S_ABORT).
  - Status-width constants.
- Sub-module erx_toggle_det: ready_q register plus tog output, with reset-time resync. Reused by the transmit-side controller.

Test Plan:
- Frame of 3 words (0x11111111, 0x22222222, 0x33333333), out_ready=1 -> 3 beats, first on beat 0, last on beat 2, err=0, frame_cnt=1, erx_cs asserted exactly 4 times.
- out_ready held 0 for 50 cycles on word 2 of 4 -> out_data and flags stable, erx_cs=0 throughout, all 4 words delivered in order.
- GETSIZE response 0 -> no beats, frame_cnt=1, back to S_IDLE.
- erx_dv pulsed during S_GETDATA at word 2 of 5, then toggle -> word 1 delivered, then data=0 last=1 err=1, err_cnt=1, new frame read from GETSIZE.
- Model withholds toggle after GETDATA -> erx_cs drops after 1024 cycles, err beat emitted, err_cnt=1, busy=0.
- erxc_rst asserted while out_valid=1 -> next cycle out_valid=0, busy=0, a later toggle starts a fresh GETSIZE with no spurious beats.
